// File: rtl/ec_pkg.sv
// Shared widths, FSM encoding and constants for the error-compensation column collector.
package ec_pkg;

    localparam int DEF_PSUM_W = 24;
    localparam int DEF_PROD_W = 16;
    localparam int DEF_CNT_W  = 8;

    localparam logic [DEF_PSUM_W-1:0] PSUM_MAX = '1;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_EMIT  = 1'b1
    } ec_state_t;

endpackage

// File: rtl/ec_sat_add.sv
// Unsigned W-bit adder exposing the carry; SATURATE clamps to all-ones on carry, else wraps.
module ec_sat_add #(
    parameter int W        = 24,
    parameter bit SATURATE = 1'b1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         carry
);

    logic [W:0] full;

    assign full  = {1'b0, a} + {1'b0, b};
    assign carry = full[W];
    assign sum   = (SATURATE && carry) ? {W{1'b1}} : full[W-1:0];

endmodule

// File: rtl/ec_column_collector.sv
// Column-bottom collector: re-injects skipped error products, accumulates one tile,
// and hands the corrected sum plus error count downstream over valid/ready.
module ec_column_collector
    import ec_pkg::*;
#(
    parameter int PSUM_W   = DEF_PSUM_W,
    parameter int PROD_W   = DEF_PROD_W,
    parameter int CNT_W    = DEF_CNT_W,
    parameter bit SATURATE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PSUM_W-1:0] psum_in,
    input  logic [PROD_W-1:0] err_product_in,
    input  logic              err_flag_in,
    input  logic              last_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PSUM_W-1:0] tile_sum,
    output logic [CNT_W-1:0]  tile_err_cnt,
    output logic              tile_sat
);

    ec_state_t         state, state_nxt;
    logic [PSUM_W-1:0] acc, acc_nxt, corr, prod_ext;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              sat, sat_nxt, corr_c, acc_c;
    logic              beat;

    // Unflagged beats contribute no product, whatever err_product_in carries.
    assign prod_ext = err_flag_in ? PSUM_W'(err_product_in) : '0;

    ec_sat_add #(.W(PSUM_W), .SATURATE(SATURATE)) u_corr_add (
        .a     (psum_in),
        .b     (prod_ext),
        .sum   (corr),
        .carry (corr_c)
    );

    ec_sat_add #(.W(PSUM_W), .SATURATE(SATURATE)) u_acc_add (
        .a     (acc),
        .b     (corr),
        .sum   (acc_nxt),
        .carry (acc_c)
    );

    assign sat_nxt = sat | corr_c | acc_c;
    assign cnt_nxt = (err_flag_in && (cnt != {CNT_W{1'b1}})) ? cnt + CNT_W'(1) : cnt;
    assign beat    = in_valid && (state == ST_ACCUM);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_ACCUM;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && last_in) state_nxt = ST_EMIT;
            end
            ST_EMIT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = ST_ACCUM;
            end
            default: state_nxt = ST_ACCUM;
        endcase
    end

    // Closing beat loads the result and clears the running state so the next tile starts at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc          <= '0;
            cnt          <= '0;
            sat          <= 1'b0;
            tile_sum     <= '0;
            tile_err_cnt <= '0;
            tile_sat     <= 1'b0;
        end else if (beat) begin
            if (last_in) begin
                tile_sum     <= acc_nxt;
                tile_err_cnt <= cnt_nxt;
                tile_sat     <= sat_nxt;
                acc          <= '0;
                cnt          <= '0;
                sat          <= 1'b0;
            end else begin
                acc <= acc_nxt;
                cnt <= cnt_nxt;
                sat <= sat_nxt;
            end
        end
    end

endmodule

// File: tb/tb_ec_column_collector.sv
// Scoreboard bench: saturating and wrapping collectors share one stimulus stream.
module tb_ec_column_collector;

    localparam int     PSUM_W = 24;
    localparam int     PROD_W = 16;
    localparam int     CNT_W  = 8;
    localparam longint MAXV   = 64'hFF_FFFF;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [PSUM_W-1:0] psum_in;
    logic [PROD_W-1:0] err_product_in;
    logic              err_flag_in;
    logic              last_in;
    logic              out_ready;

    logic              in_ready_s, out_valid_s, tile_sat_s;
    logic [PSUM_W-1:0] tile_sum_s;
    logic [CNT_W-1:0]  tile_err_cnt_s;
    logic              in_ready_w, out_valid_w, tile_sat_w;
    logic [PSUM_W-1:0] tile_sum_w;
    logic [CNT_W-1:0]  tile_err_cnt_w;

    ec_column_collector #(.PSUM_W(PSUM_W), .PROD_W(PROD_W), .CNT_W(CNT_W), .SATURATE(1'b1)) u_dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .psum_in(psum_in), .err_product_in(err_product_in), .err_flag_in(err_flag_in),
        .last_in(last_in), .out_valid(out_valid_s), .out_ready(out_ready),
        .tile_sum(tile_sum_s), .tile_err_cnt(tile_err_cnt_s), .tile_sat(tile_sat_s)
    );

    ec_column_collector #(.PSUM_W(PSUM_W), .PROD_W(PROD_W), .CNT_W(CNT_W), .SATURATE(1'b0)) u_dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
        .psum_in(psum_in), .err_product_in(err_product_in), .err_flag_in(err_flag_in),
        .last_in(last_in), .out_valid(out_valid_w), .out_ready(out_ready),
        .tile_sum(tile_sum_w), .tile_err_cnt(tile_err_cnt_w), .tile_sat(tile_sat_w)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint sum_s;
        longint sum_w;
        longint cnt;
        longint sat_s;
        longint sat_w;
    } exp_t;

    exp_t   sb[$];
    exp_t   mon_e;
    int     n_tests = 0;
    int     n_fail  = 0;
    longint m_acc_s, m_acc_w, m_cnt, m_sat_s, m_sat_w;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_acc_s = 0; m_acc_w = 0; m_cnt = 0; m_sat_s = 0; m_sat_w = 0;
    endtask

    task automatic model_beat(input longint psum, input bit flag, input longint prod, input bit last);
        longint c, a;
        exp_t   e;
        c = psum + (flag ? prod : 0);
        if (c > MAXV) begin m_sat_s = 1; c = MAXV; end
        a = m_acc_s + c;
        if (a > MAXV) begin m_sat_s = 1; a = MAXV; end
        m_acc_s = a;
        c = psum + (flag ? prod : 0);
        if (c > MAXV) begin m_sat_w = 1; c = c - (MAXV + 1); end
        a = m_acc_w + c;
        if (a > MAXV) begin m_sat_w = 1; a = a - (MAXV + 1); end
        m_acc_w = a;
        if (flag && m_cnt < 255) m_cnt++;
        if (last) begin
            e.sum_s = m_acc_s; e.sum_w = m_acc_w; e.cnt = m_cnt;
            e.sat_s = m_sat_s; e.sat_w = m_sat_w;
            sb.push_back(e);
            model_clear();
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that accepted the beat.
    task automatic send_beat(input logic [PSUM_W-1:0] psum, input bit flag,
                             input logic [PROD_W-1:0] prod, input bit last);
        int n = 0;
        in_valid = 1'b1; psum_in = psum; err_flag_in = flag;
        err_product_in = prod; last_in = last;
        while (!in_ready_s && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready_s) begin
            chk("in_ready_timeout", 64'(in_ready_s), 64'd1);
        end else begin
            @(posedge clk); #1;
            model_beat(64'(psum), flag, 64'(prod), last);
        end
        in_valid = 1'b0; last_in = 1'b0; err_flag_in = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid_s && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("sum_sat",  64'(tile_sum_s),     64'(mon_e.sum_s));
                chk("cnt_sat",  64'(tile_err_cnt_s), 64'(mon_e.cnt));
                chk("flag_sat", 64'(tile_sat_s),     64'(mon_e.sat_s));
                chk("vld_wrap", 64'(out_valid_w),    64'd1);
                chk("sum_wrap", 64'(tile_sum_w),     64'(mon_e.sum_w));
                chk("cnt_wrap", 64'(tile_err_cnt_w), 64'(mon_e.cnt));
                chk("flag_wrap", 64'(tile_sat_w),    64'(mon_e.sat_w));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; psum_in = '0; err_product_in = '0;
        err_flag_in = 1'b0; last_in = 1'b0; out_ready = 1'b1;
        model_clear();
        step(3);
        chk("rst_ov_s",   64'(out_valid_s),    64'd0);
        chk("rst_ov_w",   64'(out_valid_w),    64'd0);
        chk("rst_sum",    64'(tile_sum_s),     64'd0);
        chk("rst_cnt",    64'(tile_err_cnt_s), 64'd0);
        chk("rst_sat",    64'(tile_sat_s),     64'd0);
        chk("rst_ir",     64'(in_ready_s),     64'd1);
        rst = 1'b0;
        step(1);

        // basic two-beat tile, latency of one cycle after last
        send_beat(24'h004000, 1'b0, 16'h0000, 1'b0);
        chk("basic_ov_pre", 64'(out_valid_s), 64'd0);
        send_beat(24'h008000, 1'b1, 16'h0020, 1'b1);
        chk("basic_ov_lat", 64'(out_valid_s), 64'd1);
        chk("basic_ir_emit", 64'(in_ready_s), 64'd0);
        step(1);
        chk("basic_ir_back", 64'(in_ready_s), 64'd1);

        // mixed flags; product on unflagged beat must be ignored
        send_beat(24'h001000, 1'b1, 16'h0060, 1'b0);
        send_beat(24'h002000, 1'b0, 16'h0012, 1'b0);
        send_beat(24'h006000, 1'b1, 16'h0020, 1'b1);
        step(1);

        // backpressure: result held, beats refused
        out_ready = 1'b0;
        send_beat(24'h000300, 1'b1, 16'h0005, 1'b1);
        in_valid = 1'b1; psum_in = 24'h000777; err_flag_in = 1'b1;
        err_product_in = 16'h0011; last_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("bp_ir",  64'(in_ready_s),     64'd0);
            chk("bp_ov",  64'(out_valid_s),    64'd1);
            chk("bp_sum", 64'(tile_sum_s),     64'(sb[0].sum_s));
            chk("bp_cnt", 64'(tile_err_cnt_s), 64'(sb[0].cnt));
        end
        in_valid = 1'b0; err_flag_in = 1'b0;
        out_ready = 1'b1;
        step(1);
        chk("bp_ir_after", 64'(in_ready_s), 64'd1);
        chk("bp_ov_after", 64'(out_valid_s), 64'd0);
        send_beat(24'h000050, 1'b0, 16'h0000, 1'b1);
        step(1);

        // saturation vs wrap on the same beat
        send_beat(24'hFFFFF0, 1'b1, 16'h0020, 1'b1);
        step(1);
        // accumulate-add overflow
        send_beat(24'hF00000, 1'b0, 16'h0000, 1'b0);
        send_beat(24'h200000, 1'b0, 16'h0000, 1'b1);
        step(1);

        // reset mid-tile discards partial accumulation
        send_beat(24'h000100, 1'b1, 16'h0003, 1'b0);
        send_beat(24'h000200, 1'b1, 16'h0004, 1'b0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        model_clear();
        send_beat(24'h000100, 1'b0, 16'h0000, 1'b1);
        step(1);

        // reset during EMIT drops the pending result
        out_ready = 1'b0;
        send_beat(24'h000042, 1'b0, 16'h0000, 1'b1);
        chk("rst_emit_ov_pre", 64'(out_valid_s), 64'd1);
        void'(sb.pop_back());
        rst = 1'b1;
        step(1);
        chk("rst_emit_ov_s", 64'(out_valid_s), 64'd0);
        chk("rst_emit_ov_w", 64'(out_valid_w), 64'd0);
        chk("rst_emit_sum",  64'(tile_sum_s),  64'd0);
        chk("rst_emit_ir",   64'(in_ready_s),  64'd1);
        rst = 1'b0;
        out_ready = 1'b1;
        model_clear();
        step(1);

        // error-counter saturation over 300 flagged beats
        for (int i = 0; i < 300; i++)
            send_beat(24'h000000, 1'b1, 16'h0001, (i == 299));
        step(2);

        step(3);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
